// File: rtl/player_ctrl_pkg.sv
// Shared definitions for the player controller slice.
//   - Key bit positions of the keyboard level vector (shared with keyboard/objectbank).
//   - Game state encoding.
//   - Opposing-key resolution helper used by the position datapath.
package player_ctrl_pkg;

    localparam int unsigned KEY_W     = 5;
    localparam int unsigned KEY_UP    = 0;
    localparam int unsigned KEY_LEFT  = 1;
    localparam int unsigned KEY_DOWN  = 2;
    localparam int unsigned KEY_RIGHT = 3;
    localparam int unsigned KEY_FIRE  = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_OVER     = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    // One flag per direction that is actually applied on a motion tick.
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } move_t;

    // Opposing keys on one axis cancel each other. Without diagonal motion
    // only the highest-priority surviving key (up>down>left>right) is kept.
    function automatic move_t resolve_keys(input logic [KEY_W-1:0] keys,
                                           input logic             diag);
        move_t m;
        logic  up_ok;
        logic  dn_ok;
        logic  lf_ok;
        logic  rt_ok;
        m     = '0;
        up_ok = keys[KEY_UP]    & ~keys[KEY_DOWN];
        dn_ok = keys[KEY_DOWN]  & ~keys[KEY_UP];
        lf_ok = keys[KEY_LEFT]  & ~keys[KEY_RIGHT];
        rt_ok = keys[KEY_RIGHT] & ~keys[KEY_LEFT];
        if (diag) begin
            m.up    = up_ok;
            m.down  = dn_ok;
            m.left  = lf_ok;
            m.right = rt_ok;
        end else if (up_ok) begin
            m.up = 1'b1;
        end else if (dn_ok) begin
            m.down = 1'b1;
        end else if (lf_ok) begin
            m.left = 1'b1;
        end else if (rt_ok) begin
            m.right = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// Player controller signal bundle.
//   master: keyboard / collision side (drives keys_pressed, game_over_in, restart)
//   slave : player_ctrl (drives hpos, vpos, shift_left, shift_right, move_tick, game_over)
interface player_ctrl_if #(
    parameter int unsigned POS_W = 10
);
    import player_ctrl_pkg::*;

    logic [KEY_W-1:0] keys_pressed;
    logic             game_over_in;
    logic             restart;
    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vpos;
    logic             shift_left;
    logic             shift_right;
    logic             move_tick;
    logic             game_over;

    modport master (
        output keys_pressed, game_over_in, restart,
        input  hpos, vpos, shift_left, shift_right, move_tick, game_over
    );

    modport slave (
        input  keys_pressed, game_over_in, restart,
        output hpos, vpos, shift_left, shift_right, move_tick, game_over
    );

endinterface

// File: rtl/player_ctrl_tick_gen.sv
// tick_gen: free-running divider producing a registered one-cycle pulse.
//   clk  in  system clock
//   rst  in  asynchronous reset, active high
//   tick out high for one cycle every DIV cycles; first pulse DIV cycles
//            after reset release
module tick_gen #(
    parameter int unsigned DIV = 416667
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: player motion and game-state controller.
// Turns keyboard levels into rate-limited, bounded (clamp or wrap) position
// updates plus scroll pulses, and owns the RUN / OVER / WAIT_RELEASE state.
//   clk  in   system clock
//   rst  in   asynchronous reset, active high
//   bus  slave modport of player_ctrl_if:
//        keys_pressed/game_over_in/restart in;
//        hpos/vpos/shift_left/shift_right/move_tick/game_over out
module player_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int unsigned POS_W    = 10,
    parameter int unsigned H_MIN    = 0,
    parameter int unsigned H_MAX    = 639,
    parameter int unsigned V_MIN    = 0,
    parameter int unsigned V_MAX    = 479,
    parameter int unsigned H_INIT   = 200,
    parameter int unsigned V_INIT   = 200,
    parameter int unsigned STEP     = 1,
    parameter int unsigned TICK_DIV = 416667,
    parameter int unsigned WRAP_H   = 0,
    parameter int unsigned DIAG     = 0
) (
    input logic         clk,
    input logic         rst,
    player_ctrl_if.slave bus
);

    // Bound arithmetic is one bit wider than the position so that
    // pos+STEP can never overflow before the limit compare.
    localparam int unsigned EW = POS_W + 1;
    typedef logic [EW-1:0]    ext_t;
    typedef logic [POS_W-1:0] pos_t;

    localparam ext_t STEP_E = ext_t'(STEP);
    localparam ext_t H_MIN_E = ext_t'(H_MIN);
    localparam ext_t H_MAX_E = ext_t'(H_MAX);
    localparam ext_t V_MIN_E = ext_t'(V_MIN);
    localparam ext_t V_MAX_E = ext_t'(V_MAX);
    localparam ext_t H_LO    = ext_t'(H_MIN + STEP);
    localparam ext_t H_HI    = ext_t'(H_MAX - STEP);
    localparam ext_t V_LO    = ext_t'(V_MIN + STEP);
    localparam ext_t V_HI    = ext_t'(V_MAX - STEP);
    localparam pos_t H_INIT_P = pos_t'(H_INIT);
    localparam pos_t V_INIT_P = pos_t'(V_INIT);
    localparam logic WRAP = (WRAP_H != 0);
    localparam logic DIAG_EN = (DIAG != 0);

    state_t state_q, state_d;
    pos_t   hpos_q, hpos_d;
    pos_t   vpos_q, vpos_d;
    logic   shl_q, shl_d;
    logic   shr_q, shr_d;
    logic   tick;
    move_t  mv;
    ext_t   h_e, v_e, h_mv, v_mv;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Candidate positions if a tick were applied now.
    always_comb begin
        mv   = resolve_keys(bus.keys_pressed, DIAG_EN);
        h_e  = {1'b0, hpos_q};
        v_e  = {1'b0, vpos_q};
        h_mv = h_e;
        v_mv = v_e;
        if (mv.up) begin
            v_mv = (v_e < V_LO) ? V_MIN_E : v_e - STEP_E;
        end
        if (mv.down) begin
            v_mv = (v_e > V_HI) ? V_MAX_E : v_e + STEP_E;
        end
        if (mv.left) begin
            h_mv = (h_e < H_LO) ? (WRAP ? H_MAX_E : H_MIN_E) : h_e - STEP_E;
        end
        if (mv.right) begin
            h_mv = (h_e > H_HI) ? (WRAP ? H_MIN_E : H_MAX_E) : h_e + STEP_E;
        end
    end

    // Next state, positions and shift pulses.
    always_comb begin
        state_d = state_q;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        shl_d   = 1'b0;
        shr_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A tick coinciding with a collision still moves the player.
                if (tick) begin
                    hpos_d = pos_t'(h_mv);
                    vpos_d = pos_t'(v_mv);
                    shl_d  = mv.left;
                    shr_d  = mv.right;
                end
                if (bus.game_over_in) begin
                    state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (bus.restart) begin
                    hpos_d  = H_INIT_P;
                    vpos_d  = V_INIT_P;
                    state_d = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                // Keys held across restart must be released before play.
                if (bus.keys_pressed == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            hpos_q  <= H_INIT_P;
            vpos_q  <= V_INIT_P;
            shl_q   <= 1'b0;
            shr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
        end
    end

    assign bus.hpos        = hpos_q;
    assign bus.vpos        = vpos_q;
    assign bus.shift_left  = shl_q;
    assign bus.shift_right = shr_q;
    assign bus.move_tick   = tick;
    assign bus.game_over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: two instances (clamp/single-axis and wrap/diagonal)
// driven with identical key vectors, TICK_DIV=4, STEP=2, 0..15 field, INIT 8/8.
module tb_player_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   fails;

    player_ctrl_if #(.POS_W(5)) if_a ();
    player_ctrl_if #(.POS_W(5)) if_b ();

    player_ctrl #(
        .POS_W(5), .H_MIN(0), .H_MAX(15), .V_MIN(0), .V_MAX(15),
        .H_INIT(8), .V_INIT(8), .STEP(2), .TICK_DIV(4), .WRAP_H(0), .DIAG(0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    player_ctrl #(
        .POS_W(5), .H_MIN(0), .H_MAX(15), .V_MIN(0), .V_MAX(15),
        .H_INIT(8), .V_INIT(8), .STEP(2), .TICK_DIV(4), .WRAP_H(1), .DIAG(1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0] keys;
        int ah, av, asl, asr;
        int bh, bv, bsl, bsr;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] k, input logic goi, input logic rs);
        if_a.keys_pressed = k;
        if_b.keys_pressed = k;
        if_a.game_over_in = goi;
        if_b.game_over_in = goi;
        if_a.restart      = rs;
        if_b.restart      = rs;
    endtask

    // Returns at the negedge on which move_tick is high (bounded wait).
    task automatic wait_tick();
        int n;
        n = 0;
        while (if_a.move_tick !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (if_a.move_tick !== 1'b1) begin
            fails++;
            $display("FAIL tick_wait: got no move_tick expected one within 16 cycles");
        end
    endtask

    task automatic check_both(input string name, input int ah, input int av,
                              input int bh, input int bv);
        check({name, "_a_h"}, int'(if_a.hpos), ah);
        check({name, "_a_v"}, int'(if_a.vpos), av);
        check({name, "_b_h"}, int'(if_b.hpos), bh);
        check({name, "_b_v"}, int'(if_b.vpos), bv);
    endtask

    localparam logic [4:0] K_R = 5'b01000;

    initial begin
        int n;
        total = 0;
        fails = 0;

        tbl[0]  = '{5'b01000, 10, 8, 0, 1, 10, 8, 0, 1};
        tbl[1]  = '{5'b01000, 12, 8, 0, 1, 12, 8, 0, 1};
        tbl[2]  = '{5'b01000, 14, 8, 0, 1, 14, 8, 0, 1};
        tbl[3]  = '{5'b01000, 15, 8, 0, 1,  0, 8, 0, 1};
        tbl[4]  = '{5'b01000, 15, 8, 0, 1,  2, 8, 0, 1};
        tbl[5]  = '{5'b00010, 13, 8, 1, 0,  0, 8, 1, 0};
        tbl[6]  = '{5'b00010, 11, 8, 1, 0, 15, 8, 1, 0};
        tbl[7]  = '{5'b00011, 11, 6, 0, 0, 13, 6, 1, 0};
        tbl[8]  = '{5'b01010, 11, 6, 0, 0, 13, 6, 0, 0};
        tbl[9]  = '{5'b00111,  9, 6, 1, 0, 11, 6, 1, 0};
        tbl[10] = '{5'b00100,  9, 8, 0, 0, 11, 8, 0, 0};
        tbl[11] = '{5'b00101,  9, 8, 0, 0, 11, 8, 0, 0};
        tbl[12] = '{5'b01100,  9, 10, 0, 0, 13, 10, 0, 1};
        tbl[13] = '{5'b00001,  9, 8, 0, 0, 13, 8, 0, 0};
        tbl[14] = '{5'b00001,  9, 6, 0, 0, 13, 6, 0, 0};
        tbl[15] = '{5'b00001,  9, 4, 0, 0, 13, 4, 0, 0};
        tbl[16] = '{5'b00001,  9, 2, 0, 0, 13, 2, 0, 0};
        tbl[17] = '{5'b00001,  9, 0, 0, 0, 13, 0, 0, 0};
        tbl[18] = '{5'b00001,  9, 0, 0, 0, 13, 0, 0, 0};
        tbl[19] = '{5'b10100,  9, 2, 0, 0, 13, 2, 0, 0};

        // Reset state and free-running tick cadence.
        rst = 1'b1;
        drive(5'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_both("reset", 8, 8, 8, 8);
        check("reset_tick", int'(if_a.move_tick), 0);
        check("reset_go", int'(if_a.game_over), 0);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("tick_c%0d", k), int'(if_a.move_tick), (k % 4 == 0) ? 1 : 0);
            check($sformatf("idle_shift_c%0d", k),
                  int'({if_a.shift_left, if_a.shift_right, if_b.shift_left, if_b.shift_right}), 0);
        end
        check_both("idle", 8, 8, 8, 8);

        // Table of one-tick moves.
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].keys, 1'b0, 1'b0);
            wait_tick();
            @(negedge clk);
            check_both($sformatf("v%0d", i), tbl[i].ah, tbl[i].av, tbl[i].bh, tbl[i].bv);
            check($sformatf("v%0d_a_sl", i), int'(if_a.shift_left),  tbl[i].asl);
            check($sformatf("v%0d_a_sr", i), int'(if_a.shift_right), tbl[i].asr);
            check($sformatf("v%0d_b_sl", i), int'(if_b.shift_left),  tbl[i].bsl);
            check($sformatf("v%0d_b_sr", i), int'(if_b.shift_right), tbl[i].bsr);
            check($sformatf("v%0d_go", i), int'(if_a.game_over | if_b.game_over), 0);
        end

        // Collision and restart together in RUN: OVER wins, restart dropped.
        drive(K_R, 1'b1, 1'b1);
        @(negedge clk);
        drive(K_R, 1'b0, 1'b0);
        check("over_a", int'(if_a.game_over), 1);
        check("over_b", int'(if_b.game_over), 1);
        wait_tick();
        @(negedge clk);
        wait_tick();
        @(negedge clk);
        check_both("over_frozen", tbl[NV-1].ah, tbl[NV-1].av, tbl[NV-1].bh, tbl[NV-1].bv);
        check("over_frozen_sr", int'(if_a.shift_right | if_b.shift_right), 0);
        check("over_still", int'(if_a.game_over), 1);

        // Restart with right held: reload, then wait for release.
        drive(K_R, 1'b0, 1'b1);
        @(negedge clk);
        drive(K_R, 1'b0, 1'b0);
        check("restart_go", int'(if_a.game_over | if_b.game_over), 0);
        check_both("restart_pos", 8, 8, 8, 8);
        wait_tick();
        @(negedge clk);
        check_both("wait_rel_pos", 8, 8, 8, 8);
        check("wait_rel_sr", int'(if_a.shift_right | if_b.shift_right), 0);
        check("wait_rel_go", int'(if_a.game_over), 0);
        drive(5'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(K_R, 1'b0, 1'b0);
        wait_tick();
        @(negedge clk);
        check_both("resume", 10, 8, 10, 8);
        check("resume_sr", int'(if_a.shift_right & if_b.shift_right), 1);

        // Restart in RUN is ignored.
        drive(5'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(5'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("run_restart_go", int'(if_a.game_over), 0);
        check_both("run_restart_pos", 10, 8, 10, 8);

        // Collision on the tick cycle: move applied, then OVER.
        drive(K_R, 1'b0, 1'b0);
        wait_tick();
        drive(K_R, 1'b1, 1'b0);
        @(negedge clk);
        drive(K_R, 1'b0, 1'b0);
        check_both("tick_collide", 12, 8, 12, 8);
        check("tick_collide_sr", int'(if_a.shift_right), 1);
        check("tick_collide_go", int'(if_a.game_over & if_b.game_over), 1);

        // Asynchronous reset between edges while in OVER.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_both("async_rst", 8, 8, 8, 8);
        check("async_rst_go", int'(if_a.game_over | if_b.game_over), 0);
        check("async_rst_tick", int'(if_a.move_tick), 0);
        check("async_rst_sh", int'(if_a.shift_right | if_b.shift_right), 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (if_a.move_tick !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("first_tick_latency", n, 4);
        @(negedge clk);
        check_both("post_rst_move", 10, 8, 10, 8);
        check("post_rst_go", int'(if_a.game_over), 0);

        $display("test done: total=%0d bad=%0d", total, fails);
        $finish;
    end

endmodule
